game_level_ctrl: RTL
====================

// Module: game_level_ctrl
// PURPOSE
//  Game sequencer driving the level select consumed by the obstacle/landing-pad draw stage.
//  Runs menu -> play -> crash/land -> next level, game over or win; tracks lives.
//  Time-bases all message screens on frame ticks derived from vsync.
//  Sits between the input/collision logic and the draw pipeline (lvl 0 = no obstacles drawn).
// PARAMETERS
//  LIVES_INIT  3    lives loaded on game start (1..3)
//  NUM_LEVELS  3    last playable level (1..7)
//  MSG_FRAMES  120  frames a crash/land/game-over/win screen is held (1..255)
// PORTS
//  clk         in   1  pixel clock
//  rst         in   1  asynchronous, active-high reset
//  vsync_in    in   1  vsync from timing chain; rising edge = frame tick
//  start       in   1  debounced start button (level; edge-detected internally)
//  crash       in   1  player/obstacle collision flag
//  landed      in   1  player resting on landing pad flag
//  skip        in   1  level skip request (only with LEVEL_SKIP_EN)
//  lvl         out  3  level to draw: 0 = none, 1..NUM_LEVELS
//  lives       out  2  remaining lives
//  game_state  out  3  MENU=0 PLAY=1 CRASHED=2 LANDED=3 GAMEOVER=4 WIN=5
//  freeze      out  1  1 = player physics halted (every state except PLAY)
//  player_rst  out  1  one-cycle pulse: return player to spawn point
// BEHAVIOUR
//  - Reset values: game_state=MENU, lvl=0, lives=LIVES_INIT, freeze=1, player_rst=0.
//  - Reset also clears timer=0, start_q=0, vsync_q=0; reset mid-game returns to MENU at once.
//  - All outputs registered; a transition lands 1 clk after the triggering input is sampled.
//  - frame_tick = vsync_in & ~vsync_q, one clk wide. start_pe = start & ~start_q.
//  - timer: $clog2(MSG_FRAMES+1) bits.
//    - Cleared on every state entry.
//    - +1 per frame_tick in CRASHED/LANDED/GAMEOVER/WIN.
//    - Expiry = timer==MSG_FRAMES and frame_tick.
//  - MENU: on start_pe -> PLAY, lvl=1, lives=LIVES_INIT, player_rst=1.
//  - PLAY:
//    - crash -> CRASHED, lives=lives-1.
//    - Otherwise landed -> LANDED.
//    - crash and landed in the same cycle: crash wins.
//    - start_pe ignored.
//  - CRASHED:
//    - crash/landed ignored.
//    - On expiry: lives==0 -> GAMEOVER, lvl=0.
//    - On expiry otherwise -> PLAY, same lvl, player_rst=1.
//  - LANDED:
//    - On expiry: lvl==NUM_LEVELS -> WIN, lvl=0.
//    - On expiry otherwise -> PLAY, lvl=lvl+1, player_rst=1.
//  - GAMEOVER, WIN: on start_pe or expiry -> MENU; start_pe in the same cycle as expiry -> MENU only.
//  - lives never decrements below 0; lvl never exceeds NUM_LEVELS.
//  - player_rst asserts only on the clk PLAY is entered, then deasserts.
//  - Illegal state encodings -> MENU on next clk.
// CONFIGURATION
//  LEVEL_SKIP_EN defined:
//    - skip port present.
//    - In PLAY, skip high with crash low behaves exactly like landed.
//    - Priority: crash > landed = skip.
//  LEVEL_SKIP_EN undefined: no skip port; behaviour identical otherwise.
// TESTING
//  1. Reset asserted mid-PLAY (lvl=2, lives=1) -> same clk: state MENU, lvl=0, lives=3, freeze=1.
//  2. MENU, start pulse -> next clk: PLAY, lvl=1, lives=3; player_rst high exactly 1 clk; start held 500 clk has no further effect.
//  3. PLAY lvl=1, landed -> LANDED; after 121 frame ticks -> PLAY lvl=2 with player_rst.
//     With lvl=3, landed -> WIN, lvl=0; then MENU after 121 ticks.
//  4. Lives=1, crash and landed same clk -> CRASHED, lives=0; at expiry -> GAMEOVER.
//     start pulse in GAMEOVER -> MENU next clk.
//  5. Crash held high through CRASHED at lives=3 -> exactly one decrement (lives=2); returns to PLAY lvl unchanged.
//  6. LEVEL_SKIP_EN build: skip in PLAY lvl=2 -> LANDED, then lvl=3.
//     Skip with crash same clk -> CRASHED.

Source files
------------

// File: rtl/game_level_ctrl.sv
// ============================================================================
// game_level_ctrl
// ----------------------------------------------------------------------------
// Game sequencer for the lander game. Walks MENU -> PLAY -> CRASHED/LANDED ->
// next level, GAMEOVER or WIN, tracks lives and drives the level select used
// by the obstacle/landing-pad draw stage (lvl 0 = nothing drawn). Message
// screens are timed in frames, one frame per rising edge of vsync_in.
//
// Optional feature: define LEVEL_SKIP_EN to add the skip port. In PLAY, skip
// with crash low advances exactly like landed.
//
// Ports
//   clk         in   pixel clock
//   rst         in   asynchronous, active-high reset
//   vsync_in    in   vsync; rising edge = frame tick
//   start       in   debounced start button (level, edge-detected here)
//   crash       in   player/obstacle collision flag
//   landed      in   player on landing pad flag
//   skip        in   level skip request (LEVEL_SKIP_EN only)
//   lvl         out  level to draw, 0 = none, 1..NUM_LEVELS
//   lives       out  remaining lives
//   game_state  out  MENU=0 PLAY=1 CRASHED=2 LANDED=3 GAMEOVER=4 WIN=5
//   freeze      out  player physics halted (every state except PLAY)
//   player_rst  out  one-cycle pulse on PLAY entry: respawn the player
// ============================================================================
module game_level_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int NUM_LEVELS = 3,
    parameter int MSG_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       start,
    input  logic       crash,
    input  logic       landed,
`ifdef LEVEL_SKIP_EN
    input  logic       skip,
`endif
    output logic [2:0] lvl,
    output logic [1:0] lives,
    output logic [2:0] game_state,
    output logic       freeze,
    output logic       player_rst
);

    localparam int TW = $clog2(MSG_FRAMES + 1);

    localparam logic [2:0] S_MENU     = 3'd0;
    localparam logic [2:0] S_PLAY     = 3'd1;
    localparam logic [2:0] S_CRASHED  = 3'd2;
    localparam logic [2:0] S_LANDED   = 3'd3;
    localparam logic [2:0] S_GAMEOVER = 3'd4;
    localparam logic [2:0] S_WIN      = 3'd5;

    localparam logic [TW-1:0] MSG_T   = TW'(MSG_FRAMES);
    localparam logic [1:0]    LIVES_T = 2'(LIVES_INIT);
    localparam logic [2:0]    LAST_T  = 3'(NUM_LEVELS);

    logic [2:0]    r_state;
    logic [2:0]    r_lvl;
    logic [1:0]    r_lives;
    logic          r_freeze;
    logic          r_player_rst;
    logic [TW-1:0] r_timer;
    logic          r_vsync_q;
    logic          r_start_q;

    logic          w_frame_tick;
    logic          w_start_pe;
    logic          w_expire;
    logic          w_advance;
    logic          w_msg_state;
    logic [2:0]    w_nxt_state;
    logic [2:0]    w_nxt_lvl;
    logic [1:0]    w_nxt_lives;

    assign w_frame_tick = vsync_in & ~r_vsync_q;
    assign w_start_pe   = start & ~r_start_q;
    assign w_expire     = w_frame_tick && (r_timer == MSG_T);
    assign w_msg_state  = (r_state == S_CRASHED) || (r_state == S_LANDED) ||
                          (r_state == S_GAMEOVER) || (r_state == S_WIN);

`ifdef LEVEL_SKIP_EN
    assign w_advance = landed | skip;
`else
    assign w_advance = landed;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_lvl   = r_lvl;
        w_nxt_lives = r_lives;
        case (r_state)
            S_MENU: begin
                if (w_start_pe) begin
                    w_nxt_state = S_PLAY;
                    w_nxt_lvl   = 3'd1;
                    w_nxt_lives = LIVES_T;
                end
            end
            S_PLAY: begin
                // crash outranks landed/skip when both arrive together
                if (crash) begin
                    w_nxt_state = S_CRASHED;
                    w_nxt_lives = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
                end else if (w_advance) begin
                    w_nxt_state = S_LANDED;
                end
            end
            S_CRASHED: begin
                if (w_expire) begin
                    if (r_lives == 2'd0) begin
                        w_nxt_state = S_GAMEOVER;
                        w_nxt_lvl   = 3'd0;
                    end else begin
                        w_nxt_state = S_PLAY;
                    end
                end
            end
            S_LANDED: begin
                if (w_expire) begin
                    if (r_lvl >= LAST_T) begin
                        w_nxt_state = S_WIN;
                        w_nxt_lvl   = 3'd0;
                    end else begin
                        w_nxt_state = S_PLAY;
                        w_nxt_lvl   = r_lvl + 3'd1;
                    end
                end
            end
            S_GAMEOVER, S_WIN: begin
                if (w_start_pe || w_expire) begin
                    w_nxt_state = S_MENU;
                end
            end
            default: begin
                w_nxt_state = S_MENU;
                w_nxt_lvl   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_MENU;
            r_lvl        <= 3'd0;
            r_lives      <= LIVES_T;
            r_freeze     <= 1'b1;
            r_player_rst <= 1'b0;
            r_timer      <= '0;
            r_vsync_q    <= 1'b0;
            r_start_q    <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_lvl        <= w_nxt_lvl;
            r_lives      <= w_nxt_lives;
            r_freeze     <= (w_nxt_state != S_PLAY);
            r_player_rst <= (w_nxt_state == S_PLAY) && (r_state != S_PLAY);
            r_vsync_q    <= vsync_in;
            r_start_q    <= start;
            // Timer restarts on every state change; it only counts frames
            // while a message screen is up. Expiry leaves the state, so it
            // never runs past MSG_FRAMES.
            if (w_nxt_state != r_state)
                r_timer <= '0;
            else if (w_msg_state && w_frame_tick)
                r_timer <= r_timer + 1'b1;
        end
    end

    assign lvl        = r_lvl;
    assign lives      = r_lives;
    assign game_state = r_state;
    assign freeze     = r_freeze;
    assign player_rst = r_player_rst;

endmodule
